// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: packet-aware round-robin arbiter sharing one FIFO write port among NUM_REQ requesters
// Ports:
//   clk, rst      clock (rising edge), synchronous active-high reset
//   req           per-requester beat valid, held until granted
//   req_data      packed beats, requester i owns [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last      per-requester last-beat flag, qualified by req
//   gnt           one-hot beat accept (combinational)
//   fifo_full     FIFO full flag; blocks every grant
//   fifo_wr_en    FIFO write enable (= |gnt)
//   fifo_wr_data  granted beat, zero when idle
//   owner_id      current/last granted requester
//   busy          high while a packet holds the port
//   stat_beats, stat_stall  saturating counters, only with FIFO_WR_ARB_STATS_EN defined
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    input  logic [NUM_REQ-1:0]              req_last,
    output logic [NUM_REQ-1:0]              gnt,
    input  logic                            fifo_full,
    output logic                            fifo_wr_en,
    output logic [DATA_WIDTH-1:0]           fifo_wr_data,
    output logic [$clog2(NUM_REQ)-1:0]      owner_id,
`ifdef FIFO_WR_ARB_STATS_EN
    output logic [15:0]                     stat_beats,
    output logic [15:0]                     stat_stall,
`endif
    output logic                            busy
);
    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t        state_q;
    logic [IW-1:0] rr_ptr_q;
    logic [IW-1:0] owner_q;
    logic [7:0]    beat_cnt_q;
    logic          busy_q;

    logic [IW-1:0] win;
    logic [IW-1:0] sel;
    logic [IW-1:0] sel_nxt;
    logic          found;
    logic          go;
    logic          rel;
    int            j;

    // Scan upward from rr_ptr with wrap; the first requester found wins.
    always_comb begin
        win   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!found && req[j]) begin
                found = 1'b1;
                win   = IW'(j);
            end
        end
    end

    // Grants are suppressed during reset so a held req cannot write before the lock state is known.
    always_comb begin
        sel          = (state_q == IDLE) ? win : owner_q;
        go           = !rst && !fifo_full && ((state_q == IDLE) ? found : req[owner_q]);
        gnt          = go ? (NUM_REQ'(1) << sel) : '0;
        fifo_wr_en   = go;
        fifo_wr_data = go ? req_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH] : '0;
        rel          = req_last[sel] || ((state_q == IDLE) ? (MAX_BURST == 1)
                                                           : ({1'b0, beat_cnt_q} + 9'd1 == 9'(MAX_BURST)));
        sel_nxt      = (int'(sel) == NUM_REQ - 1) ? '0 : sel + 1'b1;
        owner_id     = owner_q;
        busy         = busy_q;
    end

    // beat_cnt is zero in IDLE, so a non-releasing IDLE grant lands on 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            beat_cnt_q <= '0;
            busy_q     <= 1'b0;
        end else if (go) begin
            owner_q <= sel;
            if (rel) begin
                state_q    <= IDLE;
                busy_q     <= 1'b0;
                rr_ptr_q   <= sel_nxt;
                beat_cnt_q <= '0;
            end else begin
                state_q    <= LOCKED;
                busy_q     <= 1'b1;
                beat_cnt_q <= beat_cnt_q + 8'd1;
            end
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    logic [15:0] stat_beats_q;
    logic [15:0] stat_stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_beats_q <= '0;
            stat_stall_q <= '0;
        end else begin
            if (go && stat_beats_q != 16'hFFFF)
                stat_beats_q <= stat_beats_q + 16'd1;
            if (|req && !go && stat_stall_q != 16'hFFFF)
                stat_stall_q <= stat_stall_q + 16'd1;
        end
    end

    assign stat_beats = stat_beats_q;
    assign stat_stall = stat_stall_q;
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: scoreboard bench for the FIFO write-port arbiter
module tb_fifo_wr_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  req_last;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [7:0]  fifo_wr_data;
    logic [1:0]  owner_id;
    logic        busy;
    logic [7:0]  d [4];
`ifdef FIFO_WR_ARB_STATS_EN
    logic [15:0] stat_beats;
    logic [15:0] stat_stall;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [3:0] g;
        logic [7:0] d;
    } exp_t;

    exp_t sb_q [$];

    always #5 clk = ~clk;

    assign req_data = {d[3], d[2], d[1], d[0]};

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_data     (req_data),
        .req_last     (req_last),
        .gnt          (gnt),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .owner_id     (owner_id),
`ifdef FIFO_WR_ARB_STATS_EN
        .stat_beats   (stat_beats),
        .stat_stall   (stat_stall),
`endif
        .busy         (busy)
    );

    // Sample this cycle's write at the falling edge, pop the scoreboard, then step past the next rising edge.
    task automatic sb_step(input logic exp_wr);
        exp_t e;
        @(negedge clk);
        n_chk++;
        if (fifo_wr_en !== exp_wr) begin
            n_fail++;
            $display("FAIL wr_en got=%b exp=%b gnt=%b t=%0t", fifo_wr_en, exp_wr, gnt, $time);
        end
        if (fifo_wr_en === 1'b1) begin
            n_chk++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_write got gnt=%b data=%h exp=none t=%0t", gnt, fifo_wr_data, $time);
            end else begin
                e = sb_q.pop_front();
                if (gnt !== e.g || fifo_wr_data !== e.d) begin
                    n_fail++;
                    $display("FAIL sb_write got gnt=%b data=%h exp gnt=%b data=%h t=%0t",
                             gnt, fifo_wr_data, e.g, e.d, $time);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [3:0] r, input logic [3:0] l, input logic [3:0] g_exp);
        logic [7:0] dv;
        dv       = '0;
        req      = r;
        req_last = l;
        for (int i = 0; i < 4; i++)
            if (g_exp[i]) dv = d[i];
        if (g_exp != 4'b0000)
            sb_q.push_back('{g: g_exp, d: dv});
        sb_step(g_exp != 4'b0000);
    endtask

    task automatic rst_pulse();
        rst      = 1'b1;
        req      = '0;
        req_last = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req       = 4'hF;
        req_last  = 4'hF;
        fifo_full = 1'b0;
        for (int i = 0; i < 4; i++) d[i] = 8'(8'h10 + i);
        @(posedge clk);
        #1;
        n_chk += 4;
        if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
        if (fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en got=%b exp=0", fifo_wr_en); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (owner_id !== 2'd0) begin n_fail++; $display("FAIL reset_owner got=%0d exp=0", owner_id); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        beat(4'hF, 4'hF, 4'b0001);
        n_chk++;
        if (owner_id !== 2'd0) begin n_fail++; $display("FAIL first_owner got=%0d exp=0", owner_id); end
        req = '0;
    endtask

    task automatic test_round_robin();
        rst_pulse();
        for (int k = 0; k < 8; k++) begin
            d[k % 4] = 8'(8'h20 + k);
            beat(4'hF, 4'hF, 4'(1 << (k % 4)));
            n_chk++;
            if (busy !== 1'b0) begin n_fail++; $display("FAIL rr_busy got=%b exp=0 k=%0d", busy, k); end
        end
        req = '0;
    endtask

    task automatic test_packet_lock();
        rst_pulse();
        d[0] = 8'h50;
        beat(4'b0001, 4'b0001, 4'b0001);
        d[1] = 8'hA1;
        beat(4'b0011, 4'b0001, 4'b0010);
        n_chk += 2;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL lock_busy got=%b exp=1", busy); end
        if (owner_id !== 2'd1) begin n_fail++; $display("FAIL lock_owner got=%0d exp=1", owner_id); end
        d[1] = 8'hA2;
        beat(4'b0011, 4'b0001, 4'b0010);
        d[1] = 8'hA3;
        beat(4'b0011, 4'b0011, 4'b0010);
        n_chk++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL lock_release got=%b exp=0", busy); end
        beat(4'b0001, 4'b0001, 4'b0001);
        n_chk++;
        if (owner_id !== 2'd0) begin n_fail++; $display("FAIL lock_next_owner got=%0d exp=0", owner_id); end
        req = '0;
    endtask

    task automatic test_max_burst();
        rst_pulse();
        d[3] = 8'hD0;
        for (int k = 0; k < 4; k++) begin
            d[2] = 8'(8'hC1 + k);
            beat(4'b1100, 4'b1000, 4'b0100);
        end
        n_chk += 2;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL burst_cut_busy got=%b exp=0", busy); end
        if (owner_id !== 2'd2) begin n_fail++; $display("FAIL burst_cut_owner got=%0d exp=2", owner_id); end
        d[2] = 8'hC5;
        beat(4'b1100, 4'b1000, 4'b1000);
        n_chk++;
        if (owner_id !== 2'd3) begin n_fail++; $display("FAIL burst_other_owner got=%0d exp=3", owner_id); end
        beat(4'b0100, 4'b0000, 4'b0100);
        n_chk++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL burst_resume_busy got=%b exp=1", busy); end
        d[2] = 8'hC6;
        beat(4'b0100, 4'b0100, 4'b0100);
        n_chk++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL burst_end_busy got=%b exp=0", busy); end
        req = '0;
    endtask

    task automatic test_full_stall();
        rst_pulse();
        d[0] = 8'hE1;
        d[2] = 8'hF0;
        beat(4'b0101, 4'b0100, 4'b0001);
        d[0]      = 8'hE2;
        fifo_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req      = 4'b0101;
            req_last = 4'b0100;
            #1;
            n_chk += 3;
            if (gnt !== 4'b0000) begin n_fail++; $display("FAIL stall_gnt got=%b exp=0000 k=%0d", gnt, k); end
            if (fifo_wr_data !== 8'h00) begin n_fail++; $display("FAIL stall_data got=%h exp=00", fifo_wr_data); end
            if (busy !== 1'b1) begin n_fail++; $display("FAIL stall_busy got=%b exp=1", busy); end
            sb_step(1'b0);
        end
        fifo_full = 1'b0;
        beat(4'b0101, 4'b0100, 4'b0001);
        d[0] = 8'hE3;
        beat(4'b0101, 4'b0100, 4'b0001);
        d[0] = 8'hE4;
        beat(4'b0101, 4'b0100, 4'b0001);
        n_chk++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL stall_cut_busy got=%b exp=0", busy); end
        d[0] = 8'hE5;
        beat(4'b0101, 4'b0100, 4'b0100);
        n_chk++;
        if (owner_id !== 2'd2) begin n_fail++; $display("FAIL stall_fair_owner got=%0d exp=2", owner_id); end
        beat(4'b0001, 4'b0001, 4'b0001);
        n_chk++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL stall_end_busy got=%b exp=0", busy); end
        req = '0;
    endtask

    task automatic test_reset_mid_locked();
        rst_pulse();
        d[0] = 8'h60;
        beat(4'b0001, 4'b0001, 4'b0001);
        d[1] = 8'hB1;
        beat(4'b0010, 4'b0000, 4'b0010);
        n_chk++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_locked got=%b exp=1", busy); end
        d[1]     = 8'hB2;
        rst      = 1'b1;
        req      = 4'b0010;
        req_last = 4'b0000;
        #1;
        n_chk++;
        if (gnt !== 4'b0000) begin n_fail++; $display("FAIL midrst_gnt got=%b exp=0000", gnt); end
        sb_step(1'b0);
        rst = 1'b0;
        n_chk += 2;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        if (owner_id !== 2'd0) begin n_fail++; $display("FAIL midrst_owner got=%0d exp=0", owner_id); end
        d[0] = 8'h61;
        beat(4'b0011, 4'b0011, 4'b0001);
        req = '0;
    endtask

    initial begin
        rst       = 1'b1;
        req       = '0;
        req_last  = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < 4; i++) d[i] = '0;
        test_reset();
        test_round_robin();
        test_packet_lock();
        test_max_burst();
        test_full_stall();
        test_reset_mid_locked();
        n_chk++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain got=%0d pending exp=0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter that shares one synchronous FIFO write port among NUM_REQ requesters.
- Packet-aware: once a requester wins, it keeps the port until it signals its last beat or reaches MAX_BURST beats.
- Sits directly in front of the FIFO write interface. It drives the FIFO's write enable and data, and observes the FIFO's full flag.
- Never issues a write while the FIFO is full.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 8, width of each data beat.
- MAX_BURST, 4, maximum beats per grant before a forced release (1..255).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  NUM_REQ  per-requester beat-valid; held until granted.
- req_data  input  NUM_REQ*DATA_WIDTH  packed beats; requester i owns bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  input  NUM_REQ  per-requester last-beat-of-packet flag, qualified by req.
- gnt  output  NUM_REQ  one-hot beat accept; a beat transfers when req[i] and gnt[i] are both high.
- fifo_full  input  1  FIFO full flag.
- fifo_wr_en  output  1  FIFO write enable.
- fifo_wr_data  output  DATA_WIDTH  FIFO write data.
- owner_id  output  clog2(NUM_REQ)  index of the current/last granted requester.
- busy  output  1  high while in LOCKED state.

Behaviour:
- Clocking and reset: one clock domain. Reset is synchronous and active-high, on clk and rst.
- Reset values: state=IDLE, rr_ptr=0, owner_id=0, beat_cnt=0, busy=0.
- Reset mid-packet: the lock is dropped; no partial-packet recovery.
- Outputs:
  - gnt, fifo_wr_en and fifo_wr_data are combinational from the registered state and the current inputs. Latency from req to write is 0 cycles.
  - fifo_wr_en = |gnt.
  - fifo_wr_data = slice of req_data selected by the granted index; all zeros when no grant.
- fifo_full high: gnt = 0 in every state; state, rr_ptr and beat_cnt all hold.
- State IDLE:
  - Scan req starting at index rr_ptr, upward with wrap. The first set bit wins; grant it this cycle.
  - Set owner_id to the winner.
  - If req_last of the winner is set, or MAX_BURST == 1: set rr_ptr = winner+1 (mod NUM_REQ) and stay in IDLE.
  - Otherwise: set beat_cnt = 1 and go to LOCKED.
  - If no req is set: no grant, no change.
- State LOCKED:
  - Only owner_id may be granted; all other req are ignored.
  - If req[owner_id] is high and the FIFO is not full: grant and increment beat_cnt.
  - If that beat has req_last set, or beat_cnt+1 == MAX_BURST: set rr_ptr = owner_id+1 (mod NUM_REQ), beat_cnt = 0, and go to IDLE.
  - If req[owner_id] is low: wait in LOCKED indefinitely (packet integrity), no grant.
- Forced release at MAX_BURST: the remaining beats of that packet compete again as a new grant. Requesters must tolerate interleaving at MAX_BURST boundaries.
- Fairness: a requester that just released has the lowest priority on the next arbitration.
- Widths: beat_cnt is 8 bits. rr_ptr wraps modulo NUM_REQ, including non-power-of-two NUM_REQ.
- Simultaneous events: release and a new arbitration never occur in the same cycle. The cycle after a release is always an IDLE arbitration cycle.
- req_last without req is ignored.

Optional Feature:
- Macro: FIFO_WR_ARB_STATS_EN.
- When defined:
  - Adds output stat_beats (16 bits): total granted beats, saturating at 0xFFFF.
  - Adds output stat_stall (16 bits): cycles where any req was high but no grant issued, saturating.
  - Both are cleared by rst.
- When undefined: neither port nor counter exists. Core behaviour is identical.

Test Plan:
- Reset then idle: rst=1 for 2 cycles with req=4'b1111 → gnt=0, busy=0, owner_id=0. After release, the first grant goes to req[0].
- Round-robin single beats: req=4'b1111, req_last=4'b1111 held for 8 cycles, fifo_full=0 → gnt sequence 0001,0010,0100,1000,0001,… and 8 FIFO writes with matching data.
- Packet lock: req1 sends 3 beats (0xA1,0xA2,0xA3, last on the third) while req0 is held high → three consecutive grants to 1, then the next grant goes to req2/req3/req0 per rr_ptr. FIFO receives A1,A2,A3 contiguous.
- MAX_BURST cut: MAX_BURST=4, req2 sends a 6-beat packet while req3 is active → 4 beats from req2, then req3 is granted, then req2 resumes.
- Full stall mid-packet: fifo_full=1 for 3 cycles during beat 2 → gnt=0, fifo_wr_en=0, beat_cnt held; beats resume unchanged once full drops, with no loss or duplicate.
- Reset mid-LOCKED: rst during beat 2 of a req1 packet → busy=0, rr_ptr=0 next cycle. With req=4'b0011 the next grant is to req0.
